// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: state encoding, vector
// geometry and a small helper used by the optional result check.
package truth_scan_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int NUM_VECTORS = 16;
  localparam int VEC_W       = 4;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SCAN = ST_SCAN,
    DONE = ST_DONE
  } scan_state_e;

  // Index of the lowest set bit of v, or 0 when v is all zeros.
  function automatic logic [VEC_W-1:0] lowest_set_idx(input logic [NUM_VECTORS-1:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int i = NUM_VECTORS - 1; i >= 0; i--) begin
      if (v[i]) begin
        r = VEC_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Bus between the scanner and the function under test / controlling logic.
// The mismatch/first_bad pair exists only when SCANNER_CHECK_EN is defined.
interface truth_table_scanner_if;
  logic        start;
  logic        s;
  logic        x;
  logic        y;
  logic        w;
  logic        z;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  ones_count;
`ifdef SCANNER_CHECK_EN
  logic        mismatch;
  logic [3:0]  first_bad;
`endif

  // Controller / function-under-test side.
  modport master (
    output start, output s,
    input  x, input y, input w, input z,
    input  busy, input done, input table_out, input ones_count
`ifdef SCANNER_CHECK_EN
    , input mismatch, input first_bad
`endif
  );

  // Scanner side.
  modport slave (
    input  start, input s,
    output x, output y, output w, output z,
    output busy, output done, output table_out, output ones_count
`ifdef SCANNER_CHECK_EN
    , output mismatch, output first_bad
`endif
  );
endinterface

// File: rtl/truth_table_scanner_settle_timer.sv
// Settle timer: counts cycles a vector has been held and flags the cycle
// in which s should be sampled. clr_i restarts the count at a new scan.
module scan_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count and expire flag; wraps to zero on expiry.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = en_i && (cnt_q == LAST_CNT);
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (expire_o) begin
      cnt_d = 4'd0;
    end else if (en_i) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: drives all 16 {x,y,w,z} vectors into a 4-input
// function, samples its output s after SETTLE_CYCLES per vector, and
// reports the table and minterm count. Define SCANNER_CHECK_EN to add the
// comparison against EXPECTED (mismatch / first_bad outputs).
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int unsigned            SETTLE_CYCLES = 1,
  parameter logic [NUM_VECTORS-1:0] EXPECTED      = 16'h0000
) (
  input  logic                 clk,
  input  logic                 reset,
  truth_table_scanner_if.slave bus
);

  localparam logic [VEC_W-1:0] LAST_IDX = 4'(NUM_VECTORS - 1);

  scan_state_e            state_q, state_d;
  logic [VEC_W-1:0]       idx_q, idx_d;
  logic [VEC_W-1:0]       vec_q, vec_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_VECTORS-1:0] table_q, table_d;
  logic [4:0]             ones_q, ones_d;
  logic                   clr_s;
  logic                   expire_s;
  logic                   s_bit_s;

  // X or Z on s is recorded as a zero.
  assign s_bit_s = (bus.s === 1'b1);

  scan_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (clr_s),
    .en_i     (state_q == SCAN),
    .expire_o (expire_s)
  );

  // Next-state, capture and next-output decode of the scan FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    table_d = table_q;
    ones_d  = ones_q;
    clr_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SCAN;
          idx_d   = '0;
          table_d = '0;
          ones_d  = 5'd0;
          clr_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (expire_s) begin
          table_d[idx_q] = s_bit_s;
          ones_d         = ones_q + {4'd0, s_bit_s};
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
    vec_d  = busy_d ? idx_d : '0;
  end

  // State, index, result and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vec_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      table_q <= '0;
      ones_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vec_q   <= vec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      table_q <= table_d;
      ones_q  <= ones_d;
    end
  end

  assign bus.x          = vec_q[3];
  assign bus.y          = vec_q[2];
  assign bus.w          = vec_q[1];
  assign bus.z          = vec_q[0];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.table_out  = table_q;
  assign bus.ones_count = ones_q;

`ifdef SCANNER_CHECK_EN
  logic             mismatch_q, mismatch_d;
  logic [VEC_W-1:0] first_bad_q, first_bad_d;

  // Compare the finished table on DONE entry; clear on an accepted start.
  always_comb begin
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    if ((state_q == SCAN) && (state_d == DONE)) begin
      mismatch_d  = (table_d != EXPECTED);
      first_bad_d = lowest_set_idx(table_d ^ EXPECTED);
    end else if ((state_q == IDLE) && bus.start) begin
      mismatch_d  = 1'b0;
      first_bad_d = '0;
    end else begin
      mismatch_d  = mismatch_q;
      first_bad_d = first_bad_q;
    end
  end

  // Check result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign bus.mismatch  = mismatch_q;
  assign bus.first_bad = first_bad_q;
`endif

endmodule
